// File: rtl/mac_sched_pkg.sv
// ============================================================================
// mac_sched_pkg : FSM encoding and tap-count constants for mac_sched
// Revision      : 1.0
// ============================================================================
`default_nettype none

package mac_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  localparam logic [3:0] TAPS_3X3 = 4'd9;
  localparam logic [3:0] TAPS_1X1 = 4'd1;

  function automatic logic [3:0] taps_of(input logic conv3x3);
    return conv3x3 ? TAPS_3X3 : TAPS_1X1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_sched_dly.sv
// ============================================================================
// mac_sched_dly : DEPTH-stage 1-bit delay line with synchronous reset
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mac_sched_dly #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (DEPTH <= 1) begin : g_single
      logic sr_q;
      logic sr_d;

      always_comb sr_d = d;

      always_ff @(posedge clk) begin
        if (rst) sr_q <= 1'b0;
        else     sr_q <= sr_d;
      end

      assign q = sr_q;
    end else begin : g_chain
      logic [DEPTH-1:0] sr_q;
      logic [DEPTH-1:0] sr_d;

      always_comb sr_d = {sr_q[DEPTH-2:0], d};

      always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
      end

      assign q = sr_q[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mac_sched.sv
// ============================================================================
// mac_sched : MAC job scheduler - issues tap/pixel/channel buffer reads
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mac_sched
  import mac_sched_pkg::*;
#(
  parameter int W_PIX  = 12,
  parameter int W_OCH  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cfg_conv3x3,
  input  logic [W_PIX-1:0] cfg_n_pix,
  input  logic [W_OCH-1:0] cfg_n_och,
  input  logic             stall_i,
  input  logic             kern_vld_o,
  output logic             busy,
  output logic             done,
  output logic             buf_rd_en,
  output logic [W_OCH+3:0] wgt_addr,
  output logic [W_PIX-1:0] fm_pix,
  output logic [3:0]       fm_tap,
  output logic             kern_vld_i,
  output logic             kern_conv3x3,
  output logic             err
);

  localparam int W_CNT  = W_PIX + W_OCH;
  localparam int W_ADDR = W_OCH + 4;

  logic [1:0]        state_q, state_d;
  logic [3:0]        tap_q, tap_d;
  logic [W_PIX-1:0]  pix_q, pix_d;
  logic [W_OCH-1:0]  och_q, och_d;
  logic [W_CNT-1:0]  cnt_q, cnt_d;
  logic [W_PIX-1:0]  n_pix_q, n_pix_d;
  logic [W_OCH-1:0]  n_och_q, n_och_d;
  logic              conv_q, conv_d;
  logic              err_q, err_d;
  logic [W_ADDR-1:0] addr_hold_q, addr_hold_d;
  logic [W_PIX-1:0]  pix_hold_q, pix_hold_d;
  logic [3:0]        tap_hold_q, tap_hold_d;

  logic              beat;
  logic              last_tap, last_pix, last_och;
  logic              in_job;
  logic [W_CNT-1:0]  total;
  logic [W_ADDR-1:0] och_ext, cur_addr;

  always_comb begin
    beat     = (state_q == ST_RUN) && !stall_i;
    in_job   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    last_tap = (tap_q == taps_of(conv_q) - 4'd1);
    last_pix = (pix_q == n_pix_q - W_PIX'(1));
    last_och = (och_q == n_och_q - W_OCH'(1));
    total    = W_CNT'(n_pix_q) * W_CNT'(n_och_q);
    och_ext  = W_ADDR'(och_q);
    // och*9 built as och*8 + och to avoid a general multiplier
    cur_addr = (conv_q ? (och_ext << 3) + och_ext : och_ext) + W_ADDR'(tap_q);
  end

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    pix_d       = pix_q;
    och_d       = och_q;
    cnt_d       = cnt_q;
    n_pix_d     = n_pix_q;
    n_och_d     = n_och_q;
    conv_d      = conv_q;
    err_d       = err_q;
    addr_hold_d = addr_hold_q;
    pix_hold_d  = pix_hold_q;
    tap_hold_d  = tap_hold_q;

    if (in_job && kern_vld_o) begin
      if (cnt_q >= total) err_d = 1'b1;
      else                cnt_d = cnt_q + W_CNT'(1);
    end
    if ((state_q == ST_IDLE) && kern_vld_o) err_d = 1'b1;

    if (beat) begin
      addr_hold_d = cur_addr;
      pix_hold_d  = pix_q;
      tap_hold_d  = tap_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          conv_d  = cfg_conv3x3;
          n_pix_d = cfg_n_pix;
          n_och_d = cfg_n_och;
          tap_d   = '0;
          pix_d   = '0;
          och_d   = '0;
          cnt_d   = '0;
          state_d = ((cfg_n_pix == '0) || (cfg_n_och == '0)) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (beat) begin
          if (!last_tap) begin
            tap_d = tap_q + 4'd1;
          end else if (!last_pix) begin
            tap_d = '0;
            pix_d = pix_q + W_PIX'(1);
          end else if (!last_och) begin
            tap_d = '0;
            pix_d = '0;
            och_d = och_q + W_OCH'(1);
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_d >= total) state_d = ST_FIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tap_q       <= '0;
      pix_q       <= '0;
      och_q       <= '0;
      cnt_q       <= '0;
      n_pix_q     <= '0;
      n_och_q     <= '0;
      conv_q      <= 1'b0;
      err_q       <= 1'b0;
      addr_hold_q <= '0;
      pix_hold_q  <= '0;
      tap_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      pix_q       <= pix_d;
      och_q       <= och_d;
      cnt_q       <= cnt_d;
      n_pix_q     <= n_pix_d;
      n_och_q     <= n_och_d;
      conv_q      <= conv_d;
      err_q       <= err_d;
      addr_hold_q <= addr_hold_d;
      pix_hold_q  <= pix_hold_d;
      tap_hold_q  <= tap_hold_d;
    end
  end

  // Address outputs show the live beat, otherwise the last issued beat
  assign wgt_addr     = beat ? cur_addr : addr_hold_q;
  assign fm_pix       = beat ? pix_q    : pix_hold_q;
  assign fm_tap       = beat ? tap_q    : tap_hold_q;
  assign buf_rd_en    = beat;
  assign busy         = in_job;
  assign done         = (state_q == ST_FIN);
  assign kern_conv3x3 = conv_q;
  assign err          = err_q;

  mac_sched_dly #(
    .DEPTH (RD_LAT)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .d   (buf_rd_en),
    .q   (kern_vld_i)
  );

endmodule

`default_nettype wire

// File: tb/tb_mac_sched.sv
// ============================================================================
// tb_mac_sched : scoreboard bench for mac_sched with a mock MAC kernel
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_mac_sched;

  localparam int W_PIX  = 12;
  localparam int W_OCH  = 8;
  localparam int RD_LAT = 2;

  typedef struct packed {
    logic [W_OCH+3:0] addr;
    logic [W_PIX-1:0] pix;
    logic [3:0]       tap;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             cfg_conv3x3;
  logic [W_PIX-1:0] cfg_n_pix;
  logic [W_OCH-1:0] cfg_n_och;
  logic             stall_i;
  logic             kern_vld_o;
  logic             busy, done, buf_rd_en, kern_vld_i, kern_conv3x3, err;
  logic [W_OCH+3:0] wgt_addr;
  logic [W_PIX-1:0] fm_pix;
  logic [3:0]       fm_tap;

  mac_sched #(
    .W_PIX  (W_PIX),
    .W_OCH  (W_OCH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_conv3x3  (cfg_conv3x3),
    .cfg_n_pix    (cfg_n_pix),
    .cfg_n_och    (cfg_n_och),
    .stall_i      (stall_i),
    .kern_vld_o   (kern_vld_o),
    .busy         (busy),
    .done         (done),
    .buf_rd_en    (buf_rd_en),
    .wgt_addr     (wgt_addr),
    .fm_pix       (fm_pix),
    .fm_tap       (fm_tap),
    .kern_vld_i   (kern_vld_i),
    .kern_conv3x3 (kern_conv3x3),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t exp_q[$];
  beat_t last_exp;
  int    beats_seen, kvo_seen, exp_results, done_cyc, cur_taps, kvi_cnt;
  bit    done_seen, expect_done, exp_err, cur_conv;
  logic  kvo_mock, kvo_inject;
  logic [RD_LAT-1:0] hist;
  int    pend[$];

  assign kern_vld_o = kvo_mock | kvo_inject;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Mock kernel: one result per TAPS accepted reads, after a random latency
  initial begin
    kvo_mock = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        pend.delete();
        kvi_cnt  = 0;
        kvo_mock = 1'b0;
      end else begin
        if (kern_vld_i === 1'b1) begin
          int t;
          kvi_cnt++;
          if (kvi_cnt % cur_taps == 0) begin
            t = cyc + int'($urandom_range(1, 3));
            if (pend.size() > 0 && t <= pend[$]) t = pend[$] + 1;
            pend.push_back(t);
          end
        end
        kvo_mock = 1'b0;
        if (pend.size() > 0 && pend[0] <= cyc) begin
          kvo_mock = 1'b1;
          void'(pend.pop_front());
        end
      end
    end
  end

  // Monitor: scoreboard pops on every read beat, per-cycle protocol checks
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hist     = '0;
        last_exp = '0;
      end else begin
        check("kern_vld_i_align", 64'(kern_vld_i), 64'(hist[RD_LAT-1]));
        if (buf_rd_en) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            check("extra_beat", 64'(wgt_addr), 64'hFFFF_FFFF);
          end else begin
            last_exp = exp_q.pop_front();
            check("beat", 64'({wgt_addr, fm_pix, fm_tap}), 64'(last_exp));
          end
        end else begin
          check("addr_hold", 64'({wgt_addr, fm_pix, fm_tap}), 64'(last_exp));
        end
        if (stall_i && busy) check("stall_gate", 64'(buf_rd_en), 64'd0);
        if (kern_vld_o) kvo_seen++;
        if (done) begin
          if (!expect_done) begin
            check("unexpected_done", 64'd1, 64'd0);
          end else begin
            check("done_results", 64'(kvo_seen), 64'(exp_results));
            check("done_beats_left", 64'(exp_q.size()), 64'd0);
            check("done_busy_low", 64'(busy), 64'd0);
            check("done_conv_held", 64'(kern_conv3x3), 64'(cur_conv));
          end
          done_seen   = 1'b1;
          done_cyc    = cyc;
          expect_done = 1'b0;
        end
        for (int i = RD_LAT - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = buf_rd_en;
      end
    end
  end

  task automatic check_zero(input string name);
    check(name, 64'({busy, done, buf_rd_en, wgt_addr, fm_pix, fm_tap, kern_vld_i, kern_conv3x3, err}), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    expect_done = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    check_zero("reset_outputs");
    @(posedge clk); #1;
  endtask

  // smode: 0 no stall, 1 random stall, 2 stall in cycles 3..5 after start
  task automatic run_job(input bit conv, input int npix, input int noch, input int smode,
                         input bit mid_start, input int abort_beat);
    int  taps, k, start_cyc;
    bit  aborted;
    taps = conv ? 9 : 1;
    for (int o = 0; o < noch; o++)
      for (int p = 0; p < npix; p++)
        for (int t = 0; t < taps; t++)
          exp_q.push_back('{addr: (W_OCH+4)'(o * taps + t), pix: W_PIX'(p), tap: 4'(t)});
    @(posedge clk); #1;
    exp_results = npix * noch;
    kvo_seen    = 0;
    beats_seen  = 0;
    kvi_cnt     = 0;
    cur_taps    = taps;
    cur_conv    = conv;
    done_seen   = 1'b0;
    expect_done = 1'b1;
    start       = 1'b1;
    cfg_conv3x3 = conv;
    cfg_n_pix   = W_PIX'(npix);
    cfg_n_och   = W_OCH'(noch);
    start_cyc   = cyc;
    @(posedge clk); #1;
    start   = 1'b0;
    k       = 1;
    aborted = 1'b0;
    while (!done_seen && k < 4000) begin
      if (abort_beat > 0 && beats_seen >= abort_beat) begin
        aborted = 1'b1;
        stall_i = 1'b0;
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        break;
      end
      if (k == 1 && npix > 0 && noch > 0)
        check("busy_after_start", 64'({busy, kern_conv3x3}), 64'({1'b1, conv}));
      case (smode)
        1:       stall_i = ($urandom_range(0, 3) == 0);
        2:       stall_i = (k >= 3 && k <= 5);
        default: stall_i = 1'b0;
      endcase
      if (mid_start && k == 3) begin
        start       = 1'b1;
        cfg_conv3x3 = ~conv;
        cfg_n_pix   = W_PIX'(7);
        cfg_n_och   = W_OCH'(3);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start   = 1'b0;
    stall_i = 1'b0;
    if (!aborted) begin
      if (!done_seen) begin
        check("done_timeout", 64'd0, 64'd1);
        do_reset();
      end else begin
        check("beat_count", 64'(beats_seen), 64'(npix * noch * taps));
        if (npix == 0 || noch == 0)
          check("zero_job_done_lat", 64'((done_cyc - start_cyc) <= 2), 64'd1);
        check("err_after_job", 64'(err), 64'(exp_err));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_conv3x3 = 1'b0; cfg_n_pix = '0; cfg_n_och = '0;
    stall_i = 1'b0; kvo_inject = 1'b0; cur_taps = 1; cur_conv = 1'b0;
    exp_err = 1'b0; expect_done = 1'b0; done_seen = 1'b0;
    beats_seen = 0; kvo_seen = 0; exp_results = 0; done_cyc = 0; kvi_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    run_job(1'b0, 4, 2, 0, 1'b0, 0);
    run_job(1'b1, 2, 2, 0, 1'b0, 0);
    run_job(1'b1, 1, 1, 2, 1'b0, 0);
    run_job(1'b0, 3, 0, 0, 1'b0, 0);
    run_job(1'b1, 0, 2, 0, 1'b0, 0);
    run_job(1'b1, 2, 2, 0, 1'b0, 5);
    run_job(1'b1, 2, 1, 0, 1'b0, 0);
    run_job(1'b1, 2, 2, 0, 1'b1, 0);

    // Result strobe while idle must raise the sticky error
    @(posedge clk); #1;
    kvo_inject = 1'b1;
    @(posedge clk); #1;
    kvo_inject = 1'b0;
    exp_err    = 1'b1;
    @(negedge clk);
    check("err_idle_kvo", 64'(err), 64'd1);

    for (int j = 0; j < 8; j++)
      run_job(1'($urandom_range(0, 1)), int'($urandom_range(1, 5)),
              int'($urandom_range(1, 4)), 1, 1'b0, 0);

    do_reset();
    check("err_cleared_by_rst", 64'(err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_sched.md
MAC_SCHED -- requirements
Module: mac_sched

Interface
REQ-001 SHALL have parameter W_PIX, default 12, output-pixel count width.
REQ-002 SHALL have parameter W_OCH, default 8, output-channel count width.
REQ-003 SHALL have parameter RD_LAT, default 1, buffer read latency in cycles (1..4).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle job request; ignored unless idle.
REQ-007 cfg_conv3x3  in  1  0: conv1x1 (1 tap), 1: conv3x3 (9 taps); sampled on accepted start.
REQ-008 cfg_n_pix  in  W_PIX  output pixels per channel; sampled on accepted start.
REQ-009 cfg_n_och  in  W_OCH  output channels; sampled on accepted start.
REQ-010 stall_i  in  1  buffer not ready; freezes issue.
REQ-011 kern_vld_o  in  1  result-valid strobe returned by MAC kernel.
REQ-012 busy  out  1  high from accepted start until done.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 buf_rd_en  out  1  read strobe to weight/feature buffers.
REQ-015 wgt_addr  out  W_OCH+4  weight-buffer address.
REQ-016 fm_pix  out  W_PIX  feature-buffer pixel index; fm_tap  out  4  tap index 0..8.
REQ-017 kern_vld_i  out  1  buf_rd_en delayed RD_LAT cycles, aligned to buffer data.
REQ-018 kern_conv3x3  out  1  mode to kernel, held stable while busy.
REQ-019 err  out  1  sticky protocol error flag.

Function
REQ-020 SHALL implement FSM IDLE -> RUN -> DRAIN -> FIN -> IDLE.
REQ-021 IDLE + start: latch cfg, go to RUN next cycle; if cfg_n_pix==0 or cfg_n_och==0, go directly to FIN (no beats issued).
REQ-022 RUN: each cycle with stall_i==0 issues one beat (buf_rd_en=1) and advances counters; with stall_i==1, buf_rd_en=0 and counters hold.
REQ-023 Loop order: tap innermost (0..TAPS-1), pix middle (0..n_pix-1), och outermost (0..n_och-1); TAPS=9 for conv3x3, 1 for conv1x1.
REQ-024 wgt_addr = och*TAPS + tap; fm_pix = pix; fm_tap = tap (0 in conv1x1); all valid only when buf_rd_en=1, otherwise hold.
REQ-025 First beat SHALL occur the cycle after start accept (if not stalled); no gaps between unstalled beats.
REQ-026 After last beat (tap, pix, och all at max), RUN -> DRAIN next cycle.
REQ-027 SHALL count kern_vld_o pulses (width W_PIX+W_OCH) while busy; DRAIN -> FIN when count reaches n_pix*n_och, including pulse arriving same cycle.
REQ-028 FIN: done=1 for exactly one cycle, busy=0 from FIN onward, next state IDLE.
REQ-029 kern_vld_i SHALL be an RD_LAT-stage shift of buf_rd_en, flushed to 0 on reset.
REQ-030 kern_conv3x3 SHALL update only on accepted start and hold through FIN.
REQ-031 err SHALL set on kern_vld_o while IDLE or when count would exceed n_pix*n_och; cleared only by rst.
REQ-032 start while busy SHALL be ignored without affecting current job or err.

Reset
REQ-033 rst SHALL force IDLE and clear all counters, delay line, err, busy, done, buf_rd_en, kern_vld_i, kern_conv3x3, wgt_addr, fm_pix, fm_tap to 0 on next edge.
REQ-034 rst mid-job SHALL abort with no done pulse; kernel reset is the system's responsibility.

Structure
REQ-035 Package mac_sched_pkg SHALL hold FSM state encoding and TAPS_3X3=9, TAPS_1X1=1 constants.
REQ-036 Delay line SHALL be sub-module mac_sched_dly (parameter DEPTH=RD_LAT, 1-bit, sync reset).

Verification
REQ-037 conv1x1, n_pix=4, n_och=2, no stall -> 8 consecutive beats, wgt_addr 0,0,0,0,1,1,1,1; done after 8th kern_vld_o.
REQ-038 conv3x3, n_pix=2, n_och=2 -> 36 beats, wgt_addr 0..8 twice then 9..17 twice; fm_tap 0..8 repeating; done after 4 kern_vld_o.
REQ-039 conv3x3, n_pix=1, n_och=1, stall_i high cycles 3-5 -> beats pause, addresses hold, 9 beats total, kern_vld_i trails buf_rd_en by RD_LAT.
REQ-040 start with n_och=0 -> no beats, done 2 cycles after start, err=0.
REQ-041 rst asserted at beat 5 of conv3x3 job -> all outputs 0 next cycle, no done; new job then completes normally.
REQ-042 kern_vld_o pulsed while IDLE, and start pulsed mid-job -> err=1 sticky; mid-job start has no effect.
